// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries fetch-stage prediction metadata alongside the
// IF/ID and ID/EX registers, checks it against the outcome computed in EX,
// drives the fetch redirect and the pipeline flushes, and counts branches
// and mispredicts.
//
// Handshake: there is no valid/ready pair here. The pipe advances on every
// clock with buble=0 and holds completely with buble=1. A redirect
// (isValid=0 with Correct_PC, plus both flush strobes) is combinational and
// is consumed by fetch at the edge that ends the cycle.
module branch_resolve_unit #(
  parameter int size  = 32,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             buble,
  input  logic [size-1:0]  if_pc,
  input  logic [size-1:0]  if_imm,
  input  logic             if_is_branch,
  input  logic             if_is_jal,
  input  logic             if_is_jalr,
  input  logic             if_pred_taken,
  input  logic             ex_taken,
  input  logic [size-1:0]  ex_jalr_target,
  output logic             isValid,
  output logic [size-1:0]  Correct_PC,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [cnt_w-1:0] branch_count,
  output logic [cnt_w-1:0] mispredict_count,
  output logic             dbg_state
);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;
  typedef enum logic [1:0] {K_BR = 2'd0, K_JAL = 2'd1, K_JALR = 2'd2} kind_t;

  // The pc itself is not kept: only its two derived addresses are ever used.
  typedef struct packed {
    logic            valid;
    kind_t           kind;
    logic            pred;
    logic [size-1:0] target;
    logic [size-1:0] fall;
  } slot_t;

  localparam logic [size-1:0] ALIGN_MASK = ~size'(1);

  state_t            state_q, state_d;
  slot_t             d_q, d_d, e_q, e_d;
  logic [cnt_w-1:0]  branch_count_q, branch_count_d;
  logic [cnt_w-1:0]  mispredict_count_q, mispredict_count_d;
  logic              resolve, mis, fire;
  logic [size-1:0]   redirect_pc;

  // Resolve the E slot: only in RUN and never while the pipe is stalled.
  always_comb begin
    mis         = 1'b0;
    redirect_pc = '0;
    resolve     = e_q.valid && !buble && (state_q == RUN);
    unique case (e_q.kind)
      K_BR: begin
        mis         = (ex_taken != e_q.pred);
        redirect_pc = ex_taken ? e_q.target : e_q.fall;
      end
      K_JAL: begin
        mis         = !e_q.pred;
        redirect_pc = e_q.target;
      end
      K_JALR: begin
        mis         = 1'b1;
        redirect_pc = ex_jalr_target & ALIGN_MASK;
      end
      default: begin
        mis         = 1'b0;
        redirect_pc = '0;
      end
    endcase
    fire = resolve && mis;
  end

  // Redirect and flush outputs; fire already excludes RECOVER and stalls.
  always_comb begin
    isValid     = !fire;
    Correct_PC  = fire ? redirect_pc : '0;
    flush_if_id = fire;
    flush_id_ex = fire;
  end

  // Next-state for the metadata slots, FSM and saturating counters.
  always_comb begin
    d_d                = d_q;
    e_d                = e_q;
    state_d            = state_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (!buble) begin
      d_d.valid  = if_is_branch | if_is_jal | if_is_jalr;
      d_d.kind   = if_is_jalr ? K_JALR : (if_is_jal ? K_JAL : K_BR);
      d_d.pred   = if_pred_taken;
      d_d.target = if_pc + if_imm;
      d_d.fall   = if_pc + size'(4);
      e_d        = d_q;
      if (fire) begin
        d_d.valid = 1'b0;
        e_d.valid = 1'b0;
      end
    end

    unique case (state_q)
      RUN:     state_d = fire ? RECOVER : RUN;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (resolve && (branch_count_q != '1))
      branch_count_d = branch_count_q + cnt_w'(1);
    if (fire && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + cnt_w'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= RUN;
      d_q                <= '0;
      e_q                <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      d_q                <= d_d;
      e_q                <= e_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vector table, hand sequences
// for reset-during-stall and counter saturation, then randomized traffic
// checked against a reference model.
module tb_branch_resolve_unit;

  localparam int SZ = 32;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          buble;
  logic [SZ-1:0] if_pc, if_imm;
  logic          if_is_branch, if_is_jal, if_is_jalr, if_pred_taken;
  logic          ex_taken;
  logic [SZ-1:0] ex_jalr_target;
  logic          isValid;
  logic [SZ-1:0] Correct_PC;
  logic          flush_if_id, flush_id_ex;
  logic [CW-1:0] branch_count, mispredict_count;
  logic          dbg_state;

  branch_resolve_unit #(.size(SZ), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .buble(buble),
    .if_pc(if_pc), .if_imm(if_imm),
    .if_is_branch(if_is_branch), .if_is_jal(if_is_jal), .if_is_jalr(if_is_jalr),
    .if_pred_taken(if_pred_taken), .ex_taken(ex_taken), .ex_jalr_target(ex_jalr_target),
    .isValid(isValid), .Correct_PC(Correct_PC),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind encoding used by the bench: 0 none, 1 BR, 2 JAL, 3 JALR
  typedef struct {
    int          kind;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        bub;
    logic        ext;
    logic [31:0] jt;
    logic        ev;
    logic [31:0] ecpc;
    logic        efl;
    logic [3:0]  ebc;
    logic [3:0]  emc;
    logic        erec;
  } vec_t;

  typedef struct {
    bit          valid;
    int          kind;
    bit          pred;
    logic [31:0] pc;
    logic [31:0] imm;
  } minfo_t;

  vec_t   vecs[$];
  minfo_t hist[$];
  int     n_cmp  = 0;
  int     n_fail = 0;

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int kind, input logic pred, input logic [31:0] pc,
                       input logic [31:0] imm, input logic bub, input logic ext,
                       input logic [31:0] jt);
    if_is_branch   = (kind == 1);
    if_is_jal      = (kind == 2);
    if_is_jalr     = (kind == 3);
    if_pred_taken  = pred;
    if_pc          = pc;
    if_imm         = imm;
    buble          = bub;
    ex_taken       = ext;
    ex_jalr_target = jt;
  endtask

  task automatic drive_random_if();
    drive($urandom_range(0, 3), 1'($urandom), $urandom, $urandom,
          1'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_isValid"}, 64'(isValid), 64'd1);
    chk({tag, "_Correct_PC"}, 64'(Correct_PC), 64'd0);
    chk({tag, "_flush_if_id"}, 64'(flush_if_id), 64'd0);
    chk({tag, "_flush_id_ex"}, 64'(flush_id_ex), 64'd0);
  endtask

  // Hold reset low for 3 cycles with random inputs, checking the reset state.
  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random_if();
      #2;
      check_idle("reset");
      chk("reset_branch_count", 64'(branch_count), 64'd0);
      chk("reset_mispredict_count", 64'(mispredict_count), 64'd0);
      chk("reset_state", 64'(dbg_state), 64'd0);
      next_cycle();
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    hist.delete();
  endtask

  function automatic vec_t mk(input int kind, input logic pred, input logic [31:0] pc,
                              input logic [31:0] imm, input logic bub, input logic ext,
                              input logic [31:0] jt, input logic ev, input logic [31:0] ecpc,
                              input logic efl, input logic [3:0] ebc, input logic [3:0] emc,
                              input logic erec);
    vec_t v;
    v.kind = kind; v.pred = pred; v.pc = pc; v.imm = imm; v.bub = bub;
    v.ext = ext; v.jt = jt; v.ev = ev; v.ecpc = ecpc; v.efl = efl;
    v.ebc = ebc; v.emc = emc; v.erec = erec;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int          fires;
    logic        rec;
    int          bc, mc;
    logic [31:0] ecpc;
    logic        ev, resolved, mis;
    int          r, kind;
    logic        bub;
    minfo_t      e, nw;

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;

    // ---- reset state ----
    do_reset();

    // ---- directed vector table (one entry per cycle) ----
    //           kind pr  pc       imm          bub ext jt       ev  cpc      fl bc mc rec
    vecs.push_back(mk(1, 1, 'h100, 'h20,        0, 0, 0,      1, 0,      0, 0, 0, 0)); // correct BR
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 1, 0,      1, 0,      0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 'h100, 'h20,        0, 0, 0,      1, 0,      0, 1, 0, 0)); // mispredicted BR
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      0, 'h104,  1, 1, 0, 0));
    vecs.push_back(mk(3, 0, 'h200, 0,           0, 0, 0,      1, 0,      0, 2, 1, 1)); // JALR
    vecs.push_back(mk(1, 1, 'h204, 'h8,         0, 0, 0,      1, 0,      0, 2, 1, 0)); // squashed BR
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 'h3F1,  0, 'h3F0,  1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 3, 2, 1));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 3, 2, 0));
    vecs.push_back(mk(1, 1, 'h300, 'h40,        0, 0, 0,      1, 0,      0, 3, 2, 0)); // stalled BR
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 3, 2, 0));
    vecs.push_back(mk(0, 0, 0,     0,           1, 0, 0,      1, 0,      0, 3, 2, 0));
    vecs.push_back(mk(0, 0, 0,     0,           1, 0, 0,      1, 0,      0, 3, 2, 0));
    vecs.push_back(mk(0, 0, 0,     0,           1, 0, 0,      1, 0,      0, 3, 2, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      0, 'h304,  1, 3, 2, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 4, 3, 1));
    vecs.push_back(mk(2, 0, 'h400, 'hFFFFFFF8,  0, 0, 0,      1, 0,      0, 4, 3, 0)); // JAL miss
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 4, 3, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      0, 'h3F8,  1, 4, 3, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 5, 4, 1));
    vecs.push_back(mk(2, 1, 'h500, 'h10,        0, 0, 0,      1, 0,      0, 5, 4, 0)); // JAL hit
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 5, 4, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 5, 4, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 6, 4, 0));
    vecs.push_back(mk(1, 0, 'h600, 'h100,       0, 0, 0,      1, 0,      0, 6, 4, 0)); // BR not-taken hit
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 6, 4, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 6, 4, 0));
    vecs.push_back(mk(0, 0, 0,     0,           0, 0, 0,      1, 0,      0, 7, 4, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].kind, vecs[i].pred, vecs[i].pc, vecs[i].imm,
            vecs[i].bub, vecs[i].ext, vecs[i].jt);
      #2;
      chk($sformatf("vec%0d_isValid", i), 64'(isValid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_Correct_PC", i), 64'(Correct_PC), 64'(vecs[i].ecpc));
      chk($sformatf("vec%0d_flush_if_id", i), 64'(flush_if_id), 64'(vecs[i].efl));
      chk($sformatf("vec%0d_flush_id_ex", i), 64'(flush_id_ex), 64'(vecs[i].efl));
      chk($sformatf("vec%0d_branch_count", i), 64'(branch_count), 64'(vecs[i].ebc));
      chk($sformatf("vec%0d_mispredict_count", i), 64'(mispredict_count), 64'(vecs[i].emc));
      chk($sformatf("vec%0d_state", i), 64'(dbg_state), 64'(vecs[i].erec));
      next_cycle();
    end

    // ---- reset released mid-stall: pipe restarts empty ----
    do_reset();
    drive(1, 1, 'h700, 'h40, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 0);   // mispredicting BR now stalled in E
    #2;
    check_idle("stall_pre_reset");
    reset = 1'b0;
    #2;
    reset = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check_idle("post_reset_stall");
      chk("post_reset_stall_bc", 64'(branch_count), 64'd0);
      next_cycle();
    end

    // ---- saturation: a JALR fetched every cycle, each resolvable one mispredicts ----
    do_reset();
    fires = 0;
    for (int i = 0; i < 60; i++) begin
      drive(3, 0, 32'h800 + 32'(i * 4), 0, 0, 0, 32'h900 + 32'(i));
      #2;
      if (!isValid) fires++;
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("sat_fires_at_least_18", 64'(fires >= 18), 64'd1);
    chk("sat_mispredict_count", 64'(mispredict_count), 64'hF);
    chk("sat_branch_count", 64'(branch_count), 64'hF);

    // ---- randomized traffic against the reference model ----
    do_reset();
    rec = 1'b0;
    bc  = 0;
    mc  = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      r    = $urandom_range(0, 9);
      kind = (r < 4) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      bub  = ($urandom_range(0, 3) == 0);
      drive(kind, 1'($urandom), $urandom, $urandom, bub, 1'($urandom), $urandom);
      #2;
      // instruction now in EX is the one fetched two advancing cycles ago
      ev = 1'b1; ecpc = '0; resolved = 1'b0; mis = 1'b0;
      if (!bub && !rec && hist.size() == 2 && hist[1].valid) begin
        e = hist[1];
        resolved = 1'b1;
        if (e.kind == 1) begin
          mis  = (ex_taken != e.pred);
          ecpc = ex_taken ? (e.pc + e.imm) : (e.pc + 32'd4);
        end else if (e.kind == 2) begin
          mis  = !e.pred;
          ecpc = e.pc + e.imm;
        end else begin
          mis  = 1'b1;
          ecpc = {ex_jalr_target[31:1], 1'b0};
        end
        if (!mis) ecpc = '0;
        ev = !mis;
      end
      chk("rnd_isValid", 64'(isValid), 64'(ev));
      chk("rnd_Correct_PC", 64'(Correct_PC), 64'(ecpc));
      chk("rnd_flush_if_id", 64'(flush_if_id), 64'(!ev));
      chk("rnd_flush_id_ex", 64'(flush_id_ex), 64'(!ev));
      chk("rnd_branch_count", 64'(branch_count), 64'(bc));
      chk("rnd_mispredict_count", 64'(mispredict_count), 64'(mc));
      chk("rnd_state", 64'(dbg_state), 64'(rec));
      @(posedge clk);
      if (resolved && bc < 15) bc++;
      if (mis && mc < 15) mc++;
      if (!bub) begin
        nw.valid = (kind != 0);
        nw.kind  = kind;
        nw.pred  = if_pred_taken;
        nw.pc    = if_pc;
        nw.imm   = if_imm;
        hist.push_front(nw);
        if (hist.size() > 2) void'(hist.pop_back());
      end
      if (mis) foreach (hist[j]) hist[j].valid = 1'b0;
      rec = mis;
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
